serial_sub_4bit: RTL and testbench
==================================

# serial_sub_4bit

Bit-serial subtractor: computes diff = a − b − bin with borrow-out, one bit per clock, LSB first, using a single full-subtractor cell. It is the subtract-direction counterpart to the team's combinational ripple-carry adder. It sits behind a valid/ready request port and a valid/ready result port, so a stimulus source or datapath can trade area for latency.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2).

- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid; a, b and bin are sampled on accept.
- in_ready  output  1  block can accept a request; high only in IDLE.
- a  input  WIDTH  minuend (unsigned).
- b  input  WIDTH  subtrahend (unsigned).
- bin  input  1  borrow-in.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer takes the result.
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin.

## Operation
- Asynchronous reset forces the FSM to IDLE and clears all registers: diff = 0, bout = 0, out_valid = 0, in_ready = 1 (state = IDLE). Reset applies immediately at any time, including mid-CALC or in DONE. The pending operation is discarded and no result is produced.
- FSM states:
  - IDLE: in_ready = 1. On in_valid=1 at a rising edge (accept), latch a → a_sr, b → b_sr, bin → brw. Clear the bit counter cnt and the result shift register, then go to CALC.
  - CALC: in_ready = 0, out_valid = 0. Each edge:
    - d = a_sr[0] ^ b_sr[0] ^ brw
    - brw ← (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw)
    - result register shifts right with d entering at the MSB
    - a_sr and b_sr shift right
    - cnt increments
  - When cnt = WIDTH−1 at an edge, that edge processes the last bit and the FSM goes to DONE.
  - DONE: out_valid = 1. diff = result register; bout = final brw. On out_ready=1 at an edge, go to IDLE.
- diff and bout are registered. They keep their last value after DONE→IDLE until the next CALC starts overwriting them; they are valid only while out_valid = 1.
- in_valid is ignored outside IDLE. a, b and bin may change freely after accept.
- out_ready is ignored outside DONE.
- Width rules: all arithmetic is modulo 2^WIDTH. bin is exactly 1 bit. cnt is $clog2(WIDTH) bits and never wraps beyond WIDTH−1.
- Full-range behaviour:
  - a = 0, b = 2^WIDTH−1, bin = 1 → diff = 0, bout = 1.
  - a = b, bin = 0 → diff = 0, bout = 0.

## Timing
- Accept edge E0 (IDLE, in_valid=1).
- CALC covers edges E1..E_WIDTH. out_valid rises after edge E_WIDTH: a 4-cycle latency at WIDTH=4.
- Result handshake completes at the first edge with out_valid=1 and out_ready=1. in_ready rises immediately after that edge.
- Earliest next accept is the edge after that, so the minimum initiation interval is WIDTH+2 cycles.
- out_valid is held indefinitely under back-pressure (out_ready=0). diff and bout stay stable throughout.
- rst_n deassertion is synchronised externally. The first accept can occur on the first edge with rst_n=1.

## Test plan
- Basic: a=4, b=1, bin=0 → out_valid 4 cycles after accept; diff=3, bout=0. Then a=1, b=1, bin=0 → diff=0, bout=0.
- Underflow: a=0, b=1, bin=0 → diff=15, bout=1. Also a=0, b=15, bin=1 → diff=0, bout=1.
- Borrow-in: a=15, b=7, bin=1 → diff=7, bout=0. Also a=5, b=5, bin=1 → diff=15, bout=1.
- Back-pressure and ignore: hold out_ready=0 for 10 cycles in DONE → out_valid, diff and bout remain stable. Toggle in_valid with new operands during CALC and DONE → result unchanged and in_ready stays 0.
- Reset mid-operation: assert rst_n=0 two cycles into CALC → immediately out_valid=0, in_ready=1, diff=0, bout=0. After release, a=9, b=3 → diff=6, bout=0.
- Exhaustive: all 512 (a, b, bin) combinations at WIDTH=4, with random out_ready stalls, checked against (a − b − bin) mod 16 and a < b+bin.

Source files
------------

// File: rtl/serial_sub_4bit_if.sv
// Request/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor; the master side is whoever drives
// operands and consumes results.
interface serial_sub_4bit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );
endinterface

// File: rtl/serial_sub_4bit.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH) with borrow-out,
// one bit per clock, LSB first, through a single full-subtractor cell.
// A request is accepted in IDLE, WIDTH cycles of CALC produce the result,
// and DONE holds it until the consumer takes it.
module serial_sub_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_sub_4bit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell acting on the current LSBs of the operand registers
  logic d_bit;
  logic brw_next;

  // One bit of difference and the borrow into the next bit position
  always_comb begin
    d_bit    = a_sr[0] ^ b_sr[0] ^ brw;
    brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
  end

  // Handshake FSM plus the serial datapath registers
  // NOTE: every register here, datapath included, is cleared by reset so the
  // outputs read 0 the instant rst_n falls; state uses <= so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            brw   <= bus.bin;
            res   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          res  <= {d_bit, res[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          brw  <= brw_next;
          // The counter parks at its last value rather than wrapping
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs come straight from registers; no combinational path from inputs
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = res;
  assign bus.bout      = brw;

endmodule

// File: tb/tb_serial_sub_4bit.sv
// Self-checking bench for serial_sub_4bit: directed cases with literal
// expectations, back-pressure, ignored requests, mid-operation reset and an
// exhaustive sweep with random result stalls against an arithmetic model.
module tb_serial_sub_4bit;

  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic clk;
  logic rst_n;

  serial_sub_4bit_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_4bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one outstanding operation, result from plain arithmetic
  bit         m_busy = 1'b0;
  int         m_accept_cyc = 0;
  int         m_diff = 0;
  int         m_bout = 0;
  int         cyc = 0;

  // Compare process: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    bit was_busy;
    bit exp_valid;
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0;
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_diff",      bus.diff,      0);
      check("rst_bout",      bus.bout,      0);
    end else begin
      was_busy  = m_busy;
      exp_valid = m_busy && (cyc - m_accept_cyc >= WIDTH + 1);
      check("in_ready",  bus.in_ready,  !m_busy);
      check("out_valid", bus.out_valid, exp_valid);
      if (exp_valid && bus.out_valid) begin
        check("diff", bus.diff, m_diff);
        check("bout", bus.bout, m_bout);
        if (bus.out_ready) m_busy = 1'b0;
      end
      if (!was_busy && bus.in_valid) begin
        m_busy       = 1'b1;
        m_accept_cyc = cyc;
        m_diff       = (int'(bus.a) - int'(bus.b) - int'(bus.bin)) & MASK;
        m_bout       = (int'(bus.a) < int'(bus.b) + int'(bus.bin)) ? 1 : 0;
      end
    end
  end

  // Present a request and hold it until accepted (called just after a posedge)
  task automatic send(input int av, input int bv, input int binv);
    bit got = 1'b0;
    bus.a        = WIDTH'(av);
    bus.b        = WIDTH'(bv);
    bus.bin      = binv[0];
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("send_accepted", got, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    bus.bin      = 1'($urandom);
  endtask

  // Wait for a result, stall for a number of cycles, then take it
  task automatic recv(input int stall, output int d, output int bo);
    bit got = 1'b0;
    d  = -1;
    bo = -1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        d   = int'(bus.diff);
        bo  = int'(bus.bout);
        break;
      end
    end
    check("recv_valid", got, 1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
    end
    // Re-read at the moment of transfer to pin stability under back-pressure
    if (got) begin
      check("hold_diff", bus.diff, d);
      check("hold_bout", bus.bout, bo);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic directed(input string name, input int av, input int bv, input int binv,
                          input int ed, input int eb, input int stall);
    int d, bo;
    send(av, bv, binv);
    recv(stall, d, bo);
    check({name, "_diff"}, d, ed);
    check({name, "_bout"}, bo, eb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, bo;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("init_in_ready",  bus.in_ready,  1);
    check("init_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    directed("basic",    4,  1, 0,  3, 0, 0);
    directed("equal",    1,  1, 0,  0, 0, 1);
    directed("under",    0,  1, 0, 15, 1, 0);
    directed("fullrng",  0, 15, 1,  0, 1, 2);
    directed("bin_a",   15,  7, 1,  7, 0, 0);
    directed("bin_b",    5,  5, 1, 15, 1, 0);

    // New requests during CALC and DONE must be ignored; then 10 stall cycles
    send(15, 7, 1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a        = WIDTH'($urandom);
      bus.b        = WIDTH'($urandom);
      bus.bin      = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    recv(10, d, bo);
    check("ignore_diff", d, 7);
    check("ignore_bout", bo, 0);

    // Reset two cycles into CALC
    send(12, 5, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready",  bus.in_ready,  1);
    check("midrst_diff",      bus.diff,      0);
    check("midrst_bout",      bus.bout,      0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    directed("after_rst", 9, 3, 0, 6, 0, 0);

    // Exhaustive sweep; the compare process checks every result
    for (int av = 0; av <= MASK; av++) begin
      for (int bv = 0; bv <= MASK; bv++) begin
        for (int bi = 0; bi < 2; bi++) begin
          send(av, bv, bi);
          recv(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, d, bo);
        end
      end
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
